// File: rtl/demux_pkg.sv
// Shared types and constants for the four-way packet stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with valid/ready handshake; a load in the
// same cycle as a drain keeps the slot full with the new beat.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demultiplexer_stream.sv
// Four-way packet demultiplexer: the select is captured on a packet's first
// beat and held until its last beat; each channel owns one registered slot.
module demultiplexer_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_last,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    busy,
    output logic [SEL_W-1:0]        cur_sel
);

    state_t           state, state_next;
    logic [SEL_W-1:0] lock_sel, lock_sel_next;
    logic [SEL_W-1:0] target;
    logic             xfer;
    logic [NUM_CH-1:0] load;

    // in_ready depends only on slot state and out_ready, never on in_valid.
    always_comb begin
        target   = (state == ST_LOCKED) ? lock_sel : in_sel;
        in_ready = !rst && (!out_valid[target] || out_ready[target]);
        xfer     = in_valid && in_ready;
        load     = '0;
        if (xfer) begin
            load[target] = 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        lock_sel_next = lock_sel;
        case (state)
            ST_IDLE: begin
                if (xfer && !in_last) begin
                    state_next    = ST_LOCKED;
                    lock_sel_next = in_sel;
                end
            end
            ST_LOCKED: begin
                if (xfer && in_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lock_sel <= '0;
        end else begin
            state    <= state_next;
            lock_sel <= lock_sel_next;
        end
    end

    assign busy    = (state == ST_LOCKED);
    assign cur_sel = lock_sel;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(in_data),
            .load_last(in_last),
            .ready    (out_ready[k]),
            .data     (out_data[k*WIDTH +: WIDTH]),
            .last     (out_last[k]),
            .valid    (out_valid[k])
        );
    end

endmodule

// File: tb/tb_demultiplexer_stream.sv
// Directed and random checks of demultiplexer_stream against a per-channel
// queue model that applies the packet routing rules directly.
module tb_demultiplexer_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]   out_last;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic         busy;
    logic [1:0]   cur_sel;

    int vectors    = 0;
    int miscompares = 0;

    // Model: one FIFO of {last,data} per channel plus packet-lock tracking.
    logic [W:0] q [4][$];
    bit         in_pkt = 1'b0;
    int         pkt_ch = 0;

    always #5 clk = ~clk;

    demultiplexer_stream #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .cur_sel  (cur_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int         tgt;
        bit         exp_rdy;
        bit         was_rst;
        logic [3:0] drn;
        #2;
        was_rst = rst;
        tgt     = in_pkt ? pkt_ch : int'(in_sel);
        exp_rdy = !rst && (q[tgt].size() == 0 || out_ready[tgt]);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            drn[k] = (q[k].size() != 0) && out_ready[k];
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            for (int k = 0; k < 4; k++) q[k].delete();
            in_pkt = 1'b0;
            pkt_ch = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drn[k]) void'(q[k].pop_front());
            end
            if (in_valid && exp_rdy) begin
                q[tgt].push_back({in_last, in_data});
                if (!in_pkt && !in_last) begin
                    in_pkt = 1'b1;
                    pkt_ch = tgt;
                end else if (in_pkt && in_last) begin
                    in_pkt = 1'b0;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), {63'd0, out_valid[k]}, {63'd0, q[k].size() != 0});
            if (q[k].size() != 0) begin
                chk($sformatf("out_data[%0d]", k), {56'd0, out_data[k*W +: W]}, {56'd0, q[k][0][W-1:0]});
                chk($sformatf("out_last[%0d]", k), {63'd0, out_last[k]}, {63'd0, q[k][0][W]});
            end
        end
        chk("busy", {63'd0, busy}, {63'd0, in_pkt});
        if (in_pkt) chk("cur_sel", {62'd0, cur_sel}, 64'(pkt_ch));
        if (was_rst) begin
            chk("cur_sel_rst", {62'd0, cur_sel}, 64'd0);
            chk("out_data_rst", {32'd0, out_data}, 64'd0);
            chk("out_last_rst", {60'd0, out_last}, 64'd0);
        end
    endtask

    task automatic beat(input logic [W-1:0] d, input logic [1:0] s, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        tick();
    endtask

    initial begin
        // Reset with a beat presented: nothing must be accepted.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'd1; in_last = 1'b0;
        out_ready = 4'hF;
        tick();
        tick();
        chk("reset_out_valid", {60'd0, out_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;

        // Packet lock: later selects are ignored.
        beat(8'h11, 2'd2, 1'b0);
        chk("lock_b1_valid", {60'd0, out_valid}, 64'b0100);
        chk("lock_b1_cur_sel", {62'd0, cur_sel}, 64'd2);
        beat(8'h22, 2'd0, 1'b0);
        chk("lock_b2_valid", {60'd0, out_valid}, 64'b0100);
        chk("lock_b2_busy", {63'd0, busy}, 64'd1);
        beat(8'h33, 2'd3, 1'b1);
        chk("lock_b3_data", {56'd0, out_data[2*W +: W]}, 64'h33);
        chk("lock_end_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b0;
        tick();

        // Backpressure on channel 1.
        out_ready = 4'b1101;
        beat(8'hA5, 2'd1, 1'b1);
        beat(8'h5A, 2'd1, 1'b1);
        chk("bp_held", {56'd0, out_data[1*W +: W]}, 64'hA5);
        out_ready = 4'hF;
        beat(8'h5A, 2'd1, 1'b1);
        chk("bp_release_valid", {63'd0, out_valid[1]}, 64'd1);
        chk("bp_release_data", {56'd0, out_data[1*W +: W]}, 64'h5A);
        in_valid = 1'b0;
        tick();

        // Channel 0 stalled full must not block channel 3.
        out_ready = 4'b1110;
        beat(8'h10, 2'd0, 1'b1);
        in_data = 8'h77; in_sel = 2'd3; in_last = 1'b1;
        #2;
        chk("indep_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("indep_out_valid", {60'd0, out_valid}, 64'b1001);
        out_ready = 4'hF;
        in_valid  = 1'b0;
        tick();

        // Reset in the middle of a 4-beat packet to channel 1.
        out_ready = 4'b0000;
        beat(8'h41, 2'd1, 1'b0);
        out_ready = 4'hF;
        beat(8'h42, 2'd1, 1'b0);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_valid", {60'd0, out_valid}, 64'd0);
        beat(8'h99, 2'd0, 1'b1);
        chk("midrst_route", {60'd0, out_valid}, 64'b0001);

        // Random stress.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_data   = W'($urandom);
            in_sel    = 2'($urandom);
            in_last   = ($urandom_range(2, 0) == 0);
            out_ready = 4'($urandom);
            tick();
        end

        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        tick();
        chk("final_empty", {60'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
